// File: rtl/spi_slave_pkg.sv
// spi_slave_pkg: FSM state encoding and default frame length shared by the SPI slave transmitter and receiver
package spi_slave_pkg;
  localparam int DATA_LEN = 8;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_DONE = 2'd2} state_e;
  localparam logic [1:0] IDLE = S_IDLE;
  localparam logic [1:0] SHIFT = S_SHIFT;
  localparam logic [1:0] DONE = S_DONE;
endpackage

// File: rtl/spi_slave_tx_if.sv
// spi_slave_tx_if: SPI slave transmit bus
//   tx_en, sck, din, din_vld           : master -> slave
//   din_rdy, so, busy, done, underrun  : slave -> master
interface spi_slave_tx_if
  import spi_slave_pkg::*;
  #(parameter int data_len = DATA_LEN);
  logic tx_en;
  logic sck;
  logic [data_len-1:0] din;
  logic din_vld;
  logic din_rdy;
  logic so;
  logic busy;
  logic done;
  logic underrun;
  modport slave (input tx_en, sck, din, din_vld, output din_rdy, so, busy, done, underrun);
  modport master (output tx_en, sck, din, din_vld, input din_rdy, so, busy, done, underrun);
endinterface

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: two-flop synchroniser plus edge register for an asynchronous input
//   clk, rst_n : clock, async active-low reset
//   d          : asynchronous input
//   rise, fall : one-clk edge pulses on the synchronised signal
module spi_sync_edge
  import spi_slave_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise,
  output logic fall
);
  logic [2:0] s;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) s <= '0;
    else s <= {s[1:0], d};
  assign rise = s[1] & ~s[2];
  assign fall = ~s[1] & s[2];
endmodule

// File: rtl/spi_slave_tx.sv
// spi_slave_tx: double-buffered SPI slave transmitter, MSB first, so driven on sck rise
//   clk, rst_n : system clock, async active-low reset
//   bus        : spi_slave_tx_if slave modport (tx_en, sck, din/din_vld/din_rdy, so, busy, done, underrun)
module spi_slave_tx
  import spi_slave_pkg::*;
  #(parameter int data_len = DATA_LEN)
(
  input logic clk,
  input logic rst_n,
  spi_slave_tx_if.slave bus
);
  localparam int cw = $clog2(data_len + 1);
  localparam logic [cw-1:0] last = cw'(data_len);
  logic [1:0] state;
  logic [cw-1:0] bit_cnt;
  logic [data_len-1:0] shifter, hold, sh_nxt;
  logic hold_full, rdy_q, so_q, done_q, under_q;
  logic rise, fall, accept, start, step, finish, full_nxt;
  spi_sync_edge u_sync (.clk(clk), .rst_n(rst_n), .d(bus.sck), .rise(rise), .fall(fall));
  always_comb begin
    accept = bus.din_vld & rdy_q;
    start = bus.tx_en & (state == IDLE) & rise;
    step = bus.tx_en & (state == SHIFT) & rise & (bit_cnt != last);
    finish = bus.tx_en & (state == SHIFT) & fall & (bit_cnt == last);
    // a frame start drains the holding register; accept cannot coincide with a drain
    full_nxt = accept | (hold_full & ~start);
    sh_nxt = start ? (hold_full ? hold : '0) : step ? shifter << 1 : shifter;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      bit_cnt <= '0;
      shifter <= '0;
      hold <= '0;
      hold_full <= 1'b0;
      rdy_q <= 1'b1;
      so_q <= 1'b0;
      done_q <= 1'b0;
      under_q <= 1'b0;
    end else begin
      hold_full <= full_nxt;
      rdy_q <= ~full_nxt;
      if (accept) hold <= bus.din;
      shifter <= sh_nxt;
      under_q <= start & ~hold_full;
      done_q <= finish;
      if (!bus.tx_en) begin
        state <= IDLE;
        bit_cnt <= '0;
        so_q <= 1'b0;
      end else if (start) begin
        state <= SHIFT;
        bit_cnt <= cw'(1);
        so_q <= sh_nxt[data_len-1];
      end else if (step) begin
        bit_cnt <= bit_cnt + cw'(1);
        so_q <= sh_nxt[data_len-1];
      end else if (finish) begin
        state <= DONE;
        so_q <= 1'b0;
      end else if (state == DONE) begin
        state <= IDLE;
        bit_cnt <= '0;
      end
    end
  assign bus.din_rdy = rdy_q;
  assign bus.so = so_q;
  assign bus.busy = state != IDLE;
  assign bus.done = done_q;
  assign bus.underrun = under_q;
endmodule

// File: tb/tb_spi_slave_tx.sv
// tb_spi_slave_tx: directed self-checking bench for spi_slave_tx
module tb_spi_slave_tx;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int n_done = 0;
  int n_under = 0;
  spi_slave_tx_if #(.data_len(8)) bus ();
  spi_slave_tx #(.data_len(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (bus.done) n_done++;
    if (bus.underrun) n_under++;
  end
  task automatic load(input logic [7:0] w);
    bit ok = 0;
    @(negedge clk);
    bus.din = w;
    bus.din_vld = 1'b1;
    for (int k = 0; k < 50 && !ok; k++) begin
      if (bus.din_rdy) ok = 1;
      @(negedge clk);
    end
    bus.din_vld = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL load_timeout got din_rdy=0 want 1 within 50 clk");
    end
  endtask
  task automatic frame(input int n, output logic [31:0] rx, output logic rdy1);
    rx = '0;
    rdy1 = 1'b0;
    for (int i = 0; i < n; i++) begin
      bus.sck = 1'b1;
      repeat (8) @(negedge clk);
      if (i == 0) rdy1 = bus.din_rdy;
      rx = {rx[30:0], bus.so};
      bus.sck = 1'b0;
      repeat (8) @(negedge clk);
    end
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.din_rdy, bus.so, bus.busy, bus.done, bus.underrun} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_outputs got %b want 10000", {bus.din_rdy, bus.so, bus.busy, bus.done, bus.underrun});
    end
  endtask
  task automatic test_single;
    logic [31:0] rx;
    logic r1;
    int d0, u0;
    load(8'hA5);
    checks++;
    if (bus.din_rdy !== 1'b0) begin
      errors++;
      $display("FAIL single_rdy_low got %b want 0", bus.din_rdy);
    end
    d0 = n_done;
    u0 = n_under;
    frame(8, rx, r1);
    checks++;
    if (rx[7:0] !== 8'hA5) begin
      errors++;
      $display("FAIL single_data got %h want a5", rx[7:0]);
    end
    checks++;
    if (r1 !== 1'b1) begin
      errors++;
      $display("FAIL single_rdy_after_rise got %b want 1", r1);
    end
    checks++;
    if (n_done - d0 != 1 || n_under - u0 != 0) begin
      errors++;
      $display("FAIL single_pulses got done=%0d under=%0d want 1 0", n_done - d0, n_under - u0);
    end
    checks++;
    if ({bus.busy, bus.so} !== 2'b00) begin
      errors++;
      $display("FAIL single_idle got busy,so=%b want 00", {bus.busy, bus.so});
    end
  endtask
  task automatic test_back_to_back;
    logic [31:0] rx;
    logic r1;
    int d0, u0;
    load(8'h3C);
    d0 = n_done;
    u0 = n_under;
    fork
      frame(16, rx, r1);
      begin
        repeat (20) @(negedge clk);
        load(8'hC3);
      end
    join
    checks++;
    if (rx[15:0] !== 16'h3CC3) begin
      errors++;
      $display("FAIL b2b_data got %h want 3cc3", rx[15:0]);
    end
    checks++;
    if (n_done - d0 != 2 || n_under - u0 != 0) begin
      errors++;
      $display("FAIL b2b_pulses got done=%0d under=%0d want 2 0", n_done - d0, n_under - u0);
    end
  endtask
  task automatic test_underrun;
    logic [31:0] rx;
    logic r1;
    int d0, u0;
    d0 = n_done;
    u0 = n_under;
    frame(8, rx, r1);
    checks++;
    if (rx[7:0] !== 8'h00) begin
      errors++;
      $display("FAIL underrun_data got %h want 00", rx[7:0]);
    end
    checks++;
    if (n_done - d0 != 1 || n_under - u0 != 1) begin
      errors++;
      $display("FAIL underrun_pulses got done=%0d under=%0d want 1 1", n_done - d0, n_under - u0);
    end
  endtask
  task automatic test_tx_en;
    logic [31:0] rx;
    logic r1;
    int d0, u0;
    load(8'hFF);
    d0 = n_done;
    frame(4, rx, r1);
    checks++;
    if (rx[3:0] !== 4'hF || bus.so !== 1'b1) begin
      errors++;
      $display("FAIL txen_partial got %h so=%b want f so=1", rx[3:0], bus.so);
    end
    bus.tx_en = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.busy, bus.so} !== 2'b00 || n_done != d0) begin
      errors++;
      $display("FAIL txen_abort got busy,so=%b done=%0d want 00 0", {bus.busy, bus.so}, n_done - d0);
    end
    bus.tx_en = 1'b1;
    repeat (2) @(negedge clk);
    d0 = n_done;
    u0 = n_under;
    frame(8, rx, r1);
    checks++;
    if (rx[7:0] !== 8'h00 || n_under - u0 != 1 || n_done - d0 != 1) begin
      errors++;
      $display("FAIL txen_reenable got %h under=%0d done=%0d want 00 1 1", rx[7:0], n_under - u0, n_done - d0);
    end
  endtask
  task automatic test_reset_mid;
    logic [31:0] rx;
    logic r1;
    int d0, u0;
    load(8'h81);
    d0 = n_done;
    frame(3, rx, r1);
    load(8'h42);
    checks++;
    if (rx[2:0] !== 3'b100) begin
      errors++;
      $display("FAIL rstmid_bits got %b want 100", rx[2:0]);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.so, bus.busy, bus.done, bus.underrun} !== 4'b0000) begin
      errors++;
      $display("FAIL rstmid_async got %b want 0000", {bus.so, bus.busy, bus.done, bus.underrun});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.din_rdy !== 1'b1 || n_done != d0) begin
      errors++;
      $display("FAIL rstmid_release got rdy=%b done=%0d want 1 0", bus.din_rdy, n_done - d0);
    end
    u0 = n_under;
    frame(8, rx, r1);
    checks++;
    if (rx[7:0] !== 8'h00 || n_under - u0 != 1) begin
      errors++;
      $display("FAIL rstmid_hold_discard got %h under=%0d want 00 1", rx[7:0], n_under - u0);
    end
  endtask
  task automatic test_hold;
    logic [31:0] rx;
    logic r1;
    bit saw_rdy = 0;
    load(8'h5A);
    bus.din = 8'hFF;
    bus.din_vld = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (bus.din_rdy) saw_rdy = 1;
    end
    bus.din_vld = 1'b0;
    checks++;
    if (saw_rdy) begin
      errors++;
      $display("FAIL hold_rdy got din_rdy=1 want 0 while full");
    end
    frame(8, rx, r1);
    checks++;
    if (rx[7:0] !== 8'h5A) begin
      errors++;
      $display("FAIL hold_data got %h want 5a", rx[7:0]);
    end
  endtask
  initial begin
    bus.tx_en = 1'b1;
    bus.sck = 1'b0;
    bus.din = '0;
    bus.din_vld = 1'b0;
    test_reset;
    test_single;
    test_back_to_back;
    test_underrun;
    test_tx_en;
    test_reset_mid;
    test_hold;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
